// File: rtl/led_blink_sequencer.sv
// rtl/led_blink_sequencer.sv - command-driven LED sequencer: off, on, N blinks, continuous blink
module led_blink_sequencer #(
    parameter int HALF_PERIOD    = 13500000,
    parameter int CNT_W          = 24,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_count,
    output logic       busy,
    output logic       done,
    output logic       led
);

    localparam logic [1:0] MODE_OFF        = 2'd0;
    localparam logic [1:0] MODE_ON         = 2'd1;
    localparam logic [1:0] MODE_BLINK_N    = 2'd2;
    localparam logic [1:0] MODE_BLINK_CONT = 2'd3;

    localparam logic LED_LIT   = LED_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic LED_UNLIT = ~LED_LIT;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LIT,
        ST_DARK
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [7:0]       remaining, remaining_n;
    logic             cont, cont_n;
    logic             done_n;
    logic             led_n;
    logic             accept;

    assign cmd_ready = (state == ST_IDLE) | cont;
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            remaining <= '0;
            cont      <= 1'b0;
            done      <= 1'b0;
            led       <= LED_UNLIT;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            remaining <= remaining_n;
            cont      <= cont_n;
            done      <= done_n;
            led       <= led_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        remaining_n = remaining;
        cont_n      = cont;
        done_n      = 1'b0;
        led_n       = led;

        case (state)
            ST_LIT: begin
                if (timer == TIMER_LAST) begin
                    timer_n = '0;
                    led_n   = LED_UNLIT;
                    state_n = ST_DARK;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_DARK: begin
                if (timer == TIMER_LAST) begin
                    timer_n = '0;
                    if (cont) begin
                        led_n   = LED_LIT;
                        state_n = ST_LIT;
                    end else if (remaining > 8'd1) begin
                        remaining_n = remaining - 8'd1;
                        led_n       = LED_LIT;
                        state_n     = ST_LIT;
                    end else begin
                        remaining_n = '0;
                        state_n     = ST_IDLE;
                        done_n      = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
            end
        endcase

        // An accepted command wins over any phase transition, which is how
        // a continuous blink gets preempted without ever reporting done.
        if (accept) begin
            timer_n     = '0;
            remaining_n = '0;
            cont_n      = 1'b0;
            case (cmd_mode)
                MODE_ON: begin
                    led_n   = LED_LIT;
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
                MODE_BLINK_N: begin
                    if (cmd_count == 8'd0) begin
                        led_n   = LED_UNLIT;
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        remaining_n = cmd_count;
                        led_n       = LED_LIT;
                        state_n     = ST_LIT;
                        done_n      = 1'b0;
                    end
                end
                MODE_BLINK_CONT: begin
                    cont_n  = 1'b1;
                    led_n   = LED_LIT;
                    state_n = ST_LIT;
                    done_n  = 1'b0;
                end
                default: begin
                    led_n   = LED_UNLIT;
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb/tb_led_blink_sequencer.sv - scoreboard bench for led_blink_sequencer
module tb_led_blink_sequencer;

    localparam int HP = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_count = 8'd0;
    logic       busy;
    logic       done;
    logic       led;

    led_blink_sequencer #(
        .HALF_PERIOD   (HP),
        .CNT_W         (4),
        .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode (cmd_mode),
        .cmd_count(cmd_count),
        .busy     (busy),
        .done     (done),
        .led      (led)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Expected vector order: {led, busy, cmd_ready, done}
    task automatic push_exp(input int c, input logic l, input logic b, input logic r, input logic d);
        exp_t e;
        e.cyc = c;
        e.v   = {l, b, r, d};
        exp_q.push_back(e);
    endtask

    task automatic push_blink(input int a, input int n, input logic rdy);
        for (int j = 0; j < n; j++)
            push_exp(a + j, ((j / HP) % 2) != 0, 1'b1, rdy, 1'b0);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] mode, input logic [7:0] count, output int acc);
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_count = count;
        acc       = cyc + 1;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        int   d;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc != cyc || {led, busy, cmd_ready, done} !== e.v) begin
                n_fail++;
                $display("FAIL trace cyc=%0d (expected for cyc %0d) actual {led,busy,ready,done}=%b required=%b",
                         cyc, e.cyc, {led, busy, cmd_ready, done}, e.v);
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected cyc=%0d actual done=1 required done=0", cyc);
            end else begin
                d = done_q.pop_front();
                if (d != cyc) begin
                    n_fail++;
                    $display("FAIL done_cycle actual=%0d required=%0d", cyc, d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, b;

        wait_cyc(3);
        sys_rst_n = 1'b1;

        // Idle after reset
        for (int c = 3; c < 23; c++) push_exp(c, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_cyc(22);

        // BLINK_N 3
        send(2'd2, 8'd3, a);
        push_blink(a, 24, 1'b0);
        push_exp(a + 24, 1'b1, 1'b0, 1'b1, 1'b1);
        done_q.push_back(a + 24);
        wait_cyc(a + 24);

        // BLINK_N 0 then ON
        send(2'd2, 8'd0, a);
        push_exp(a, 1'b1, 1'b0, 1'b1, 1'b1);
        push_exp(a + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        done_q.push_back(a);
        send(2'd1, 8'd0, a2);
        push_exp(a2, 1'b0, 1'b0, 1'b1, 1'b1);
        push_exp(a2 + 1, 1'b0, 1'b0, 1'b1, 1'b0);
        done_q.push_back(a2);
        wait_cyc(a2 + 2);

        // BLINK_CONT preempted by ON mid-DARK
        send(2'd3, 8'd0, a);
        push_blink(a, 22, 1'b1);
        wait_cyc(a + 20);
        send(2'd1, 8'd0, a2);
        push_exp(a2, 1'b0, 1'b0, 1'b1, 1'b1);
        push_exp(a2 + 1, 1'b0, 1'b0, 1'b1, 1'b0);
        done_q.push_back(a2);
        wait_cyc(a2 + 2);

        // BLINK_N 2 with cmd_valid held; re-accepted in the done cycle
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_count = 8'd2;
        a = cyc + 1;
        push_blink(a, 16, 1'b0);
        push_exp(a + 16, 1'b1, 1'b0, 1'b1, 1'b1);
        done_q.push_back(a + 16);
        push_blink(a + 17, 16, 1'b0);
        push_exp(a + 33, 1'b1, 1'b0, 1'b1, 1'b1);
        done_q.push_back(a + 33);
        wait_cyc(a + 17);
        cmd_valid = 1'b0;
        wait_cyc(a + 34);

        // Asynchronous reset mid-LIT of BLINK_N 5
        send(2'd2, 8'd5, a);
        push_blink(a, 2, 1'b0);
        wait_cyc(a + 2);
        push_exp(a + 2, 1'b1, 1'b0, 1'b1, 1'b0);
        push_exp(a + 3, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = a + 4; c < a + 10; c++) push_exp(c, 1'b1, 1'b0, 1'b1, 1'b0);
        sys_rst_n = 1'b0;
        wait_cyc(a + 4);
        sys_rst_n = 1'b1;
        wait_cyc(a + 8);
        send(2'd2, 8'd1, b);
        push_blink(b, 8, 1'b0);
        push_exp(b + 8, 1'b1, 1'b0, 1'b1, 1'b1);
        done_q.push_back(b + 8);
        wait_cyc(b + 12);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL trace_drained actual=%0d left required=0", exp_q.size());
        end
        n_checks++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_drained actual=%0d missing required=0", done_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
- Command-driven controller for a single board LED. It replaces the free-running half-second toggle with sequenced patterns: off, on, N blinks, or continuous blink.
- Accepts one command at a time over a valid/ready handshake, times each blink phase with an internal half-period counter, and pulses done when a finite sequence completes.
- Sits between a requester (button logic, UART command decoder, status FSM) and the LED pin.

Parameters:
- HALF_PERIOD, 13500000, clock cycles per lit phase and per dark phase (0.5 s at 27 MHz); legal range 2 .. 2**CNT_W.
- CNT_W, 24, width of the phase timer.
- LED_ACTIVE_LOW, 1, 1: LED lit when led=0; 0: LED lit when led=1.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted this cycle.
- cmd_mode  input  2  0=OFF, 1=ON, 2=BLINK_N, 3=BLINK_CONT.
- cmd_count  input  8  blink count for BLINK_N; ignored otherwise.
- busy  output  1  sequence in progress (state != IDLE).
- done  output  1  one-cycle pulse when a command completes.
- led  output  1  LED drive, registered.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, timer=0, remaining=0, cont=0, done=0.
  - led=unlit level (1 when LED_ACTIVE_LOW=1).
  - busy=0, cmd_ready=1 (combinational). Handshakes are ignored while sys_rst_n=0.
- Accept: cmd_valid & cmd_ready sampled at an edge. led/state update on that same edge, so the new output is visible in the cycle after the handshake.
- cmd_ready = (state==IDLE) | cont. A counted blink cannot be interrupted; a continuous blink can be preempted.
- IDLE, accepting a command:
  - OFF: led unlit, stay IDLE, done=1 next cycle.
  - ON: led lit, stay IDLE, done=1 next cycle.
  - BLINK_N with cmd_count=0: treated exactly as OFF.
  - BLINK_N with cmd_count=N>0: remaining=N, cont=0, timer=0, led lit, go LIT.
  - BLINK_CONT: cont=1, timer=0, led lit, go LIT.
- LIT:
  - led lit; timer increments each cycle.
  - When timer==HALF_PERIOD-1: timer=0, led unlit, go DARK.
- DARK:
  - led unlit; timer increments each cycle.
  - When timer==HALF_PERIOD-1, timer=0, then:
    - cont=1: led lit, go LIT.
    - cont=0 and remaining>1: remaining-1, led lit, go LIT.
    - cont=0 and remaining==1: remaining=0, go IDLE, done=1 for exactly one cycle. led stays unlit.
- Timing:
  - Each phase lasts exactly HALF_PERIOD cycles.
  - A BLINK_N sequence occupies 2*N*HALF_PERIOD cycles from the acceptance edge to the done edge.
- Preempt: a handshake while cont=1 (LIT or DARK) aborts the blink.
  - The new command is processed as if from IDLE on that edge; the timer restarts at 0.
  - No done pulse is issued for the aborted BLINK_CONT.
  - OFF/ON preempts clear cont and return to IDLE with done.
- done is never asserted for more than one consecutive cycle unless back-to-back commands each complete.
- A command may be accepted in the same cycle done=1, because cmd_ready is 1 in IDLE.
- Reset mid-sequence: immediately returns to the reset state; led unlit, no done pulse.
- Timer wrap: the timer never exceeds HALF_PERIOD-1; no modular overflow path exists.

Test Plan (HALF_PERIOD=4, LED_ACTIVE_LOW=1):
- Reset released, no commands -> led=1, busy=0, cmd_ready=1, done=0 held for 20 cycles.
- BLINK_N, count=3 -> led pattern 0000 1111 repeated 3 times (24 cycles).
  - busy=1 and cmd_ready=0 throughout.
  - done=1 one cycle at cycle 24 after acceptance; led=1; busy=0.
- BLINK_N with count=0, then ON -> each gives done one cycle after acceptance.
  - led stays 1 after count=0, then becomes 0 after ON.
- BLINK_CONT run for 20 cycles, then ON issued mid-DARK.
  - Before ON: led toggles every 4 cycles, cmd_ready=1, no done.
  - After ON: led=0 next cycle, busy=0, single done.
- BLINK_N count=2 with cmd_valid held high during sequence -> not accepted until done cycle.
  - Accepted in the done cycle and restarts LIT immediately.
- sys_rst_n pulsed low mid-LIT of BLINK_N count=5 -> led=1 and busy=0 asynchronously; no done pulse; next command runs normally.
